// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte handshake for the UART receiver.
// The slave modport is the receiver itself; the master modport is the side
// that owns the line and consumes the received bytes.
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       rx_busy;

   modport master (
      output rx,
      input  rx_data,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_parity_err,
      input  rx_busy
   );

   modport slave (
      input  rx,
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_parity_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, 8 data bits LSB first, optional even
// parity bit, 1 stop bit. Every bit is sampled at its middle by counting
// CLKS_PER_BIT clocks from the half-bit point of the start bit.
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// between data bit 7 and the stop bit. Without it, rx_parity_err is tied 0.
// All outputs are registered; the three pulse outputs are mutually exclusive.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   // Line timing, in system clocks.
   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'((CLKS_PER_BIT / 2) - 1);

   // FSM encoding.
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY    = 3'd3;
`endif
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

`ifdef UART_RX_PARITY_EN
   // Even parity: the XOR of the eight data bits is the bit the sender
   // appends, so a received parity bit differing from it is a mismatch.
   function automatic logic parity_of(input logic [7:0] value);
      return ^value;
   endfunction
`endif

   // Synchronizer and synchronized line.
   logic [1:0]  sync_r;
   logic        rx_s;

   // FSM registers.
   logic [2:0]  state_r;
   logic [15:0] clk_count_r;
   logic [2:0]  bit_index_r;
   logic [7:0]  shift_r;

   // Output registers.
   logic [7:0]  data_r;
   logic        valid_r;
   logic        frame_err_r;
   logic        busy_r;

   // Next-state values.
   logic [2:0]  state_nxt;
   logic [15:0] count_nxt;
   logic [2:0]  index_nxt;
   logic [7:0]  shift_nxt;
   logic [7:0]  data_nxt;
   logic        valid_nxt;
   logic        frame_err_nxt;
   logic        busy_nxt;

`ifdef UART_RX_PARITY_EN
   logic        parity_mis_r;
   logic        parity_err_r;
   logic        parity_mis_nxt;
   logic        parity_err_nxt;
`endif

   assign rx_s = sync_r[1];

   // Two-flop synchronizer for the asynchronous line; idles at 1 so reset
   // never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], bus.rx};
      end
   end

   // Frame decoder: next state, bit counters, shift register and outputs.
   always_comb begin
      state_nxt     = state_r;
      count_nxt     = clk_count_r;
      index_nxt     = bit_index_r;
      shift_nxt     = shift_r;
      data_nxt      = data_r;
      valid_nxt     = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_mis_nxt = parity_mis_r;
      parity_err_nxt = 1'b0;
`endif

      case (state_r)
         IDLE: begin
            if (rx_s == 1'b0) begin
               state_nxt = START;
               count_nxt = 16'd0;
`ifdef UART_RX_PARITY_EN
               parity_mis_nxt = 1'b0;
`endif
            end else begin
               state_nxt = IDLE;
            end
         end

         START: begin
            // Re-check the line half a bit in; a high here was only a glitch.
            if (clk_count_r == HALF_LAST) begin
               count_nxt = 16'd0;
               if (rx_s == 1'b0) begin
                  state_nxt = DATA;
                  index_nxt = 3'd0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               count_nxt = clk_count_r + 16'd1;
            end
         end

         DATA: begin
            if (clk_count_r == BIT_LAST) begin
               shift_nxt[bit_index_r] = rx_s;
               count_nxt = 16'd0;
               if (bit_index_r == 3'd7) begin
                  index_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  index_nxt = bit_index_r + 3'd1;
               end
            end else begin
               count_nxt = clk_count_r + 16'd1;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (clk_count_r == BIT_LAST) begin
               parity_mis_nxt = rx_s ^ parity_of(shift_r);
               count_nxt      = 16'd0;
               state_nxt      = STOP;
            end else begin
               count_nxt = clk_count_r + 16'd1;
            end
         end
`endif

         STOP: begin
            // Exit at mid-stop-bit so a start bit right behind it is caught.
            if (clk_count_r == BIT_LAST) begin
               count_nxt = 16'd0;
               if (rx_s == 1'b1) begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (parity_mis_r) begin
                     parity_err_nxt = 1'b1;
                  end else begin
                     data_nxt  = shift_r;
                     valid_nxt = 1'b1;
                  end
`else
                  data_nxt  = shift_r;
                  valid_nxt = 1'b1;
`endif
               end else begin
                  // Framing error outranks any parity error.
                  frame_err_nxt = 1'b1;
                  state_nxt     = WAIT_HIGH;
               end
            end else begin
               count_nxt = clk_count_r + 16'd1;
            end
         end

         WAIT_HIGH: begin
            // Hold off until the line returns high so a break is one error.
            if (rx_s == 1'b1) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT_HIGH;
            end
         end

         default: begin
            state_nxt = IDLE;
            count_nxt = 16'd0;
            index_nxt = 3'd0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // FSM and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         clk_count_r <= 16'd0;
         bit_index_r <= 3'd0;
         shift_r     <= 8'h00;
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         clk_count_r <= count_nxt;
         bit_index_r <= index_nxt;
         shift_r     <= shift_nxt;
         data_r      <= data_nxt;
         valid_r     <= valid_nxt;
         frame_err_r <= frame_err_nxt;
         busy_r      <= busy_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch flag and parity error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_mis_r <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         parity_mis_r <= parity_mis_nxt;
         parity_err_r <= parity_err_nxt;
      end
   end

   assign bus.rx_parity_err = parity_err_r;
`else
   assign bus.rx_parity_err = 1'b0;
`endif

   assign bus.rx_data      = data_r;
   assign bus.rx_valid     = valid_r;
   assign bus.rx_frame_err = frame_err_r;
   assign bus.rx_busy      = busy_r;

endmodule
